// File: rtl/i2c_result_tx_scheduler.sv
// I2C result to UART issue scheduler.
// PC results queue in a FIFO; defaults overwrite a one-entry slot.
module i2c_result_tx_scheduler #(
  parameter int DW          = 16,
  parameter int AW          = 8,
  parameter int FW          = 6,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i2c_data_rdy,
  input  logic [1:0]                   i2c_valid_instr,
  input  logic [DW-1:0]                i2c_retrieved_data,
  input  logic [AW-1:0]                i2c_instr_address,
  input  logic [7:0]                   i2c_op_info,
  input  logic [FW-1:0]                failure_signal,
  input  logic                         tx_complete,
  output logic                         data_ready,
  output logic [DW-1:0]                toPC_data,
  output logic [FW+1:0]                toPC_mode,
  output logic [AW-1:0]                toPC_address,
  output logic                         full_i2cbuffer,
  output logic                         empty_i2cbuffer,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [CNT_W-1:0]             drop_count,
  output logic [CNT_W-1:0]             timeout_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(ACK_TIMEOUT+1);
  localparam int MW = FW+2;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DW-1:0] r_fdata [DEPTH];
  logic [AW-1:0] r_faddr [DEPTH];
  logic [FW-1:0] r_ffail [DEPTH];
  logic [1:0]    r_fop2  [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic          r_def_vld;
  logic [DW-1:0] r_def_data;
  logic [FW-1:0] r_def_fail;

  logic [TW-1:0]    r_tmr;
  logic [CNT_W-1:0] r_drop, r_tout;

  logic          r_dr;
  logic [DW-1:0] r_data;
  logic [MW-1:0] r_mode;
  logic [AW-1:0] r_addr;

  logic w_pc_push, w_def_push, w_push_ok, w_pop;
  logic w_sel_fifo, w_sel_def, w_sel_byp, w_issue, w_timeout;
  logic [1:0]    w_op2;
  logic [DW-1:0] w_iss_data;
  logic [MW-1:0] w_iss_mode;
  logic [AW-1:0] w_iss_addr;

  assign w_pc_push  = i2c_data_rdy && (i2c_valid_instr == 2'b11);
  assign w_def_push = i2c_data_rdy && (i2c_valid_instr == 2'b01);
  assign w_pop      = w_sel_fifo;
  assign w_push_ok  = w_pc_push && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_issue    = w_sel_fifo | w_sel_def | w_sel_byp;

  // One-hot op code to 2-bit op field; malformed codes map to 0.
  always_comb begin
    w_op2 = 2'b00;
    case (i2c_op_info[3:0])
      4'b0001: w_op2 = 2'b00;
      4'b0010: w_op2 = 2'b01;
      4'b0100: w_op2 = 2'b10;
      4'b1000: w_op2 = 2'b11;
      default: w_op2 = 2'b00;
    endcase
  end

  // Handshake FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and source selection; FIFO wins over the default slot.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_fifo  = 1'b0;
    w_sel_def   = 1'b0;
    w_sel_byp   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tx_complete) begin
          if (r_count != '0)   w_sel_fifo = 1'b1;
          else if (r_def_vld)  w_sel_def  = 1'b1;
          else if (w_def_push) w_sel_byp  = 1'b1;
        end
        if (w_sel_fifo || w_sel_def || w_sel_byp)
          w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_complete) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_tmr == TW'(ACK_TIMEOUT-1)) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_complete) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue record mux.
  always_comb begin
    w_iss_data = r_def_data;
    w_iss_mode = {r_def_fail, 2'b01};
    w_iss_addr = '0;
    if (w_sel_fifo) begin
      w_iss_data = r_fdata[r_rptr];
      w_iss_mode = {r_ffail[r_rptr], r_fop2[r_rptr]};
      w_iss_addr = r_faddr[r_rptr];
    end else if (w_sel_byp) begin
      w_iss_data = i2c_retrieved_data;
      w_iss_mode = {failure_signal, 2'b01};
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fdata[r_wptr] <= i2c_retrieved_data;
      r_faddr[r_wptr] <= i2c_instr_address;
      r_ffail[r_wptr] <= failure_signal;
      r_fop2[r_wptr]  <= w_op2;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Default slot: a new load always wins over consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_def_vld  <= 1'b0;
      r_def_data <= '0;
      r_def_fail <= '0;
    end else if (w_def_push && !w_sel_byp) begin
      r_def_vld  <= 1'b1;
      r_def_data <= i2c_retrieved_data;
      r_def_fail <= failure_signal;
    end else if (w_sel_def) begin
      r_def_vld  <= 1'b0;
    end
  end

  // Ack timer and saturating drop/timeout counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr  <= '0;
      r_drop <= '0;
      r_tout <= '0;
    end else begin
      if (w_issue)                    r_tmr <= '0;
      else if (r_state == S_WAIT_BUSY) r_tmr <= r_tmr + 1'b1;
      if (w_pc_push && !w_push_ok && (r_drop != '1))
        r_drop <= r_drop + 1'b1;
      if (w_timeout && (r_tout != '1))
        r_tout <= r_tout + 1'b1;
    end
  end

  // Registered issue outputs; payload holds until the next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dr   <= 1'b0;
      r_data <= '0;
      r_mode <= '0;
      r_addr <= '0;
    end else begin
      r_dr <= w_issue;
      if (w_issue) begin
        r_data <= w_iss_data;
        r_mode <= w_iss_mode;
        r_addr <= w_iss_addr;
      end
    end
  end

  assign data_ready      = r_dr;
  assign toPC_data       = r_data;
  assign toPC_mode       = r_mode;
  assign toPC_address    = r_addr;
  assign fifo_count      = r_count;
  assign full_i2cbuffer  = (r_count == CW'(DEPTH));
  assign empty_i2cbuffer = (r_count == '0);
  assign drop_count      = r_drop;
  assign timeout_count   = r_tout;

endmodule

// File: tb/tb_i2c_result_tx_scheduler.sv
// Directed bench for i2c_result_tx_scheduler.
// Expected values are hand-computed per vector.
module tb_i2c_result_tx_scheduler;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2c_data_rdy;
  logic [1:0]  i2c_valid_instr;
  logic [15:0] i2c_retrieved_data;
  logic [7:0]  i2c_instr_address;
  logic [7:0]  i2c_op_info;
  logic [5:0]  failure_signal;
  logic        tx_complete;
  logic        data_ready;
  logic [15:0] toPC_data;
  logic [7:0]  toPC_mode;
  logic [7:0]  toPC_address;
  logic        full_i2cbuffer;
  logic        empty_i2cbuffer;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;
  logic [7:0]  timeout_count;

  int n_chk  = 0;
  int n_fail = 0;
  int dr_cnt = 0;

  i2c_result_tx_scheduler #(
    .DW(16), .AW(8), .FW(6), .DEPTH(4),
    .ACK_TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i2c_data_rdy(i2c_data_rdy),
    .i2c_valid_instr(i2c_valid_instr),
    .i2c_retrieved_data(i2c_retrieved_data),
    .i2c_instr_address(i2c_instr_address),
    .i2c_op_info(i2c_op_info),
    .failure_signal(failure_signal),
    .tx_complete(tx_complete),
    .data_ready(data_ready),
    .toPC_data(toPC_data),
    .toPC_mode(toPC_mode),
    .toPC_address(toPC_address),
    .full_i2cbuffer(full_i2cbuffer),
    .empty_i2cbuffer(empty_i2cbuffer),
    .fifo_count(fifo_count),
    .drop_count(drop_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_ready === 1'b1) dr_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pc_push(input logic [15:0] d, input logic [7:0] a,
                         input logic [7:0] op, input logic [5:0] f);
    i2c_data_rdy       = 1'b1;
    i2c_valid_instr    = 2'b11;
    i2c_retrieved_data = d;
    i2c_instr_address  = a;
    i2c_op_info        = op;
    failure_signal     = f;
    tick();
    i2c_data_rdy    = 1'b0;
    i2c_valid_instr = 2'b00;
  endtask

  task automatic def_push(input logic [15:0] d, input logic [5:0] f);
    i2c_data_rdy       = 1'b1;
    i2c_valid_instr    = 2'b01;
    i2c_retrieved_data = d;
    i2c_instr_address  = 8'hEE;
    i2c_op_info        = 8'h08;
    failure_signal     = f;
    tick();
    i2c_data_rdy    = 1'b0;
    i2c_valid_instr = 2'b00;
  endtask

  // Release the UART, wait for one issue, then go busy again.
  task automatic issue_wait(input string tag, input logic [15:0] ed,
                            input logic [7:0] em, input logic [7:0] ea);
    bit got = 1'b0;
    tx_complete = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (data_ready === 1'b1) got = 1'b1;
    end
    chk({tag, "_rdy"},  32'(got), 32'd1);
    chk({tag, "_data"}, 32'(toPC_data), 32'(ed));
    chk({tag, "_mode"}, 32'(toPC_mode), 32'(em));
    chk({tag, "_addr"}, 32'(toPC_address), 32'(ea));
    tx_complete = 1'b0;
    tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dr"},   32'(data_ready), 32'd0);
    chk({tag, "_data"}, 32'(toPC_data), 32'd0);
    chk({tag, "_mode"}, 32'(toPC_mode), 32'd0);
    chk({tag, "_addr"}, 32'(toPC_address), 32'd0);
    chk({tag, "_cnt"},  32'(fifo_count), 32'd0);
    chk({tag, "_empty"}, 32'(empty_i2cbuffer), 32'd1);
    chk({tag, "_full"}, 32'(full_i2cbuffer), 32'd0);
    chk({tag, "_drop"}, 32'(drop_count), 32'd0);
    chk({tag, "_tout"}, 32'(timeout_count), 32'd0);
  endtask

  initial begin
    reset              = 1'b1;
    i2c_data_rdy       = 1'b0;
    i2c_valid_instr    = 2'b00;
    i2c_retrieved_data = '0;
    i2c_instr_address  = '0;
    i2c_op_info        = '0;
    failure_signal     = '0;
    tx_complete        = 1'b1;
    repeat (3) tick();
    chk_reset_state("rst0");

    // Default push bypassed straight to issue.
    reset = 1'b0;
    def_push(16'h1234, 6'h00);
    chk("byp_dr",   32'(data_ready), 32'd1);
    chk("byp_data", 32'(toPC_data), 32'h1234);
    chk("byp_mode", 32'(toPC_mode), 32'h01);
    chk("byp_addr", 32'(toPC_address), 32'h00);
    tx_complete = 1'b0;
    tick();
    chk("byp_pulse", 32'(data_ready), 32'd0);

    // Five PC pushes while busy: one drop.
    for (int i = 0; i < 5; i++)
      pc_push(16'h0100 + 16'(i), 8'h10 + 8'(i), 8'h04, 6'h00);
    chk("fill_cnt",  32'(fifo_count), 32'd4);
    chk("fill_full", 32'(full_i2cbuffer), 32'd1);
    chk("fill_drop", 32'(drop_count), 32'd1);
    for (int i = 0; i < 4; i++)
      issue_wait("fifo", 16'h0100 + 16'(i), 8'h02, 8'h10 + 8'(i));
    chk("drain_empty", 32'(empty_i2cbuffer), 32'd1);
    chk("drain_issues", 32'(dr_cnt), 32'd5);

    // PC priority over default slot; newest default wins.
    pc_push(16'h2000, 8'h20, 8'h03, 6'h05);
    def_push(16'h0AAA, 6'h00);
    def_push(16'h0BBB, 6'h03);
    issue_wait("prio_pc", 16'h2000, 8'h14, 8'h20);
    issue_wait("prio_def", 16'h0BBB, 8'h0D, 8'h00);
    tx_complete = 1'b1;
    repeat (8) tick();
    chk("no_stale_def", 32'(dr_cnt), 32'd7);

    // Handshake timeout with tx_complete stuck high.
    def_push(16'h5555, 6'h00);
    chk("to_dr",   32'(data_ready), 32'd1);
    chk("to_data", 32'(toPC_data), 32'h5555);
    repeat (TO + 5) tick();
    chk("to_count", 32'(timeout_count), 32'd1);
    chk("to_nodup", 32'(dr_cnt), 32'd8);

    // Full FIFO: pop and push in the same cycle.
    tx_complete = 1'b0;
    for (int i = 0; i < 4; i++)
      pc_push(16'h3000 + 16'(i), 8'h30 + 8'(i), 8'h08, 6'h00);
    chk("full2", 32'(full_i2cbuffer), 32'd1);
    tx_complete = 1'b1;
    pc_push(16'h3004, 8'h34, 8'h08, 6'h00);
    chk("pp_dr",   32'(data_ready), 32'd1);
    chk("pp_addr", 32'(toPC_address), 32'h30);
    chk("pp_cnt",  32'(fifo_count), 32'd4);
    chk("pp_drop", 32'(drop_count), 32'd1);
    tx_complete = 1'b0;
    tick();
    issue_wait("pp_next", 16'h3001, 8'h03, 8'h31);
    chk("pre_rst_cnt", 32'(fifo_count), 32'd3);

    // Reset while in WAIT_DONE with entries queued.
    reset       = 1'b1;
    tx_complete = 1'b1;
    tick();
    chk_reset_state("rst1");
    reset = 1'b0;
    repeat (10) tick();
    chk("rst_no_issue", 32'(dr_cnt), 32'd10);

    // Restart after reset.
    pc_push(16'h4444, 8'h40, 8'h02, 6'h00);
    issue_wait("restart", 16'h4444, 8'h01, 8'h40);
    chk("restart_issues", 32'(dr_cnt), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_result_tx_scheduler.md
Name: i2c_result_tx_scheduler

Overview:
Parametrised successor to the I2C-to-UART result arbiter. Sits between the I2C controller result outputs and the UART transmitter. PC-instruction results are queued in a single record FIFO of configurable depth. The newest default temperature read is held in a one-entry overwrite slot rather than being discarded. Each record is issued to the UART exactly once, under a tx_complete handshake FSM with a timeout, and dropped results are counted.

Parameters:
DW, 16, result data width
AW, 8, instruction address width
FW, 6, failure-signal width; mode byte = FW+2 bits
DEPTH, 4, PC-result FIFO depth; power of 2, at least 2
ACK_TIMEOUT, 1024, cycles to wait for tx_complete to fall after issue
CNT_W, 8, drop/timeout counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i2c_data_rdy  in  1  result valid this cycle
i2c_valid_instr  in  2  2'b11 = PC instruction, 2'b01 = default read, others ignored
i2c_retrieved_data  in  DW  result data
i2c_instr_address  in  AW  instruction address
i2c_op_info  in  8  operation code; bits [3:0] one-hot
failure_signal  in  FW  failure flags
tx_complete  in  1  UART idle/done (level)
data_ready  out  1  one-cycle issue strobe to UART
toPC_data  out  DW  issued data
toPC_mode  out  FW+2  {failure, op2}
toPC_address  out  AW  issued address
full_i2cbuffer  out  1  FIFO count == DEPTH
empty_i2cbuffer  out  1  FIFO count == 0
fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy
drop_count  out  CNT_W  saturating count of dropped PC results
timeout_count  out  CNT_W  saturating count of handshake timeouts

Behaviour:
- Reset: all outputs 0, except empty_i2cbuffer = 1. FIFO is emptied, default slot is invalid, FSM goes to IDLE, timers clear. Reset in any state aborts the transfer; no data_ready is issued.
- PC push: i2c_data_rdy && valid_instr==2'b11.
  - Accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and drop_count increments, saturating at all-ones.
- Record contents: {data, address, failure, op2}. op2 is decoded at push time:
  - op_info[3:0] 0001→00, 0010→01, 0100→10, 1000→11
  - any other value → 00
- Default push: i2c_data_rdy && valid_instr==2'b01 loads the default slot with {data, failure} and sets it valid.
  - A new default push overwrites an existing valid entry.
  - A load in the same cycle the slot is consumed leaves the new value valid.
- Selection, in IDLE with tx_complete==1:
  - FIFO non-empty: pop the FIFO head. PC results have strict priority.
  - Else, default slot valid: consume the slot. Mode = {failure, 2'b01}, address = 0.
  - Else, a default push arriving this cycle is bypassed directly to issue; the slot stays invalid.
- Issue: the selected record is registered onto the toPC_* outputs and data_ready=1 for exactly one cycle. The outputs appear the cycle after selection (latency 1).
- toPC_* hold their value until the next issue; they are not cleared. data_ready is otherwise 0.
- FSM:
  - IDLE: on issue → WAIT_BUSY, timer = 0.
  - WAIT_BUSY: tx_complete==0 → WAIT_DONE. If timer reaches ACK_TIMEOUT-1 with tx_complete still 1 → IDLE, timeout_count increments (saturating), and the record is treated as delivered (no re-issue).
  - WAIT_DONE: tx_complete==1 → IDLE. No issue is allowed in the same cycle; earliest re-issue selection is one cycle later.
- Pushes continue in all FSM states. Pops occur only on selection in IDLE.
- FIFO pointers wrap modulo DEPTH. full_i2cbuffer and empty_i2cbuffer are derived combinationally from the registered count.

Test Plan:
- Reset, tx_complete=1, default push data=0x1234, fail=0 → next cycle data_ready=1, toPC_data=0x1234, toPC_mode=0x01, toPC_address=0; FSM enters WAIT_BUSY.
- tx_complete=0 (UART busy); 5 PC pushes with DEPTH=4 (addr 0x10..0x14, op 0100) → fifo_count=4, full=1, drop_count=1. Then run handshakes → issues in order 0x10..0x13, each with mode op2=10, one data_ready per handshake.
- With the FIFO holding 1 entry and the default slot valid, tx_complete=1 → the PC entry is issued first and the default issues on the following handshake. Two default pushes (0x0AAA then 0x0BBB) made while busy → only 0x0BBB is issued.
- After issue, hold tx_complete=1 for ACK_TIMEOUT cycles → timeout_count=1, return to IDLE, no duplicate data_ready.
- FIFO full and a pop in IDLE coincide with a PC push → push accepted, drop_count unchanged, fifo_count stays 4.
- Assert reset while in WAIT_DONE with 3 entries queued → all outputs 0, empty=1, fifo_count=0, no data_ready afterwards until new pushes arrive.
